// File: rtl/uart_mem_ctrl_if.sv
// Bundle of UART-side and memory-side signals for the byte-command controller.
// The controller (memory initiator) takes the master modport; the UART pair
// and the data memory together form the slave side.
interface uart_mem_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] Address;
  logic        MemWrite;
  logic        ler;
  logic [7:0]  WriteData;
  logic [7:0]  ReadData;
  logic        busy;
  logic        err;

  modport master (
    input  rx_valid, rx_data, tx_busy, ReadData,
    output tx_start, tx_data, Address, MemWrite, ler, WriteData, busy, err
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, ReadData,
    input  tx_start, tx_data, Address, MemWrite, ler, WriteData, busy, err
  );
endinterface

// File: rtl/uart_mem_ctrl.sv
// Byte-command controller: parses 'W' (57) / 'R' (52) commands arriving on
// the UART receiver, performs one range-checked memory access and returns
// either the read byte or ACK_BYTE to the UART transmitter.
module uart_mem_ctrl #(
  parameter int         MEM_DEPTH = 501,
  parameter int         RD_WAIT   = 2,
  parameter int         TIMEOUT   = 1_000_000,
  parameter logic [7:0] ACK_BYTE  = 8'h4B
) (
  input  logic              Clock,
  input  logic              Reset,
  uart_mem_ctrl_if.master   bus
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RD_W  = (RD_WAIT > 1) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_HI  = 3'd1,
    S_A_LO  = 3'd2,
    S_DAT   = 3'd3,
    S_WR    = 3'd4,
    S_RD    = 3'd5,
    S_SEND  = 3'd6,
    S_ABORT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [7:0]       addr_hi_q, addr_hi_d;
  logic [7:0]       addr_lo_q, addr_lo_d;
  logic [15:0]      address_q, address_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             mem_write_q, mem_write_d;
  logic             ler_q, ler_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;

  // Address is legal when it falls inside the populated memory.
  function automatic logic in_range(input logic [15:0] a);
    return ({16'h0000, a} < 32'(MEM_DEPTH));
  endfunction

  // Outputs come straight from registers; tx_start is qualified with the live
  // tx_busy so a request can never collide with an occupied transmitter.
  assign bus.Address   = {16'h0000, address_q};
  assign bus.WriteData = wdata_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.ler       = ler_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.tx_start  = (state_q == S_SEND) && !bus.tx_busy;

  // Next-state and next-output logic for the command parser and access sequencer.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_hi_d   = addr_hi_q;
    addr_lo_d   = addr_lo_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    mem_write_d = 1'b0;
    ler_d       = 1'b0;
    err_d       = 1'b0;
    tmo_d       = tmo_q;
    rd_cnt_d    = rd_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if ((bus.rx_data == OP_WR) || (bus.rx_data == OP_RD)) begin
            is_wr_d = (bus.rx_data == OP_WR);
            tmo_d   = CNT_W'(1);
            state_d = S_A_HI;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_A_HI: begin
        if (bus.rx_valid) begin
          addr_hi_d = bus.rx_data;
          tmo_d     = CNT_W'(1);
          state_d   = S_A_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      S_A_LO: begin
        if (bus.rx_valid) begin
          addr_lo_d = bus.rx_data;
          tmo_d     = CNT_W'(1);
          if (is_wr_q) begin
            state_d = S_DAT;
          end else if (in_range({addr_hi_q, bus.rx_data})) begin
            address_d = {addr_hi_q, bus.rx_data};
            ler_d     = 1'b1;
            rd_cnt_d  = '0;
            state_d   = S_RD;
          end else begin
            err_d   = 1'b1;
            state_d = S_ABORT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      S_DAT: begin
        if (bus.rx_valid) begin
          if (in_range({addr_hi_q, addr_lo_q})) begin
            address_d   = {addr_hi_q, addr_lo_q};
            wdata_d     = bus.rx_data;
            mem_write_d = 1'b1;
            state_d     = S_WR;
          end else begin
            err_d   = 1'b1;
            state_d = S_ABORT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      S_WR: begin
        tx_data_d = ACK_BYTE;
        state_d   = S_SEND;
      end

      S_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          tx_data_d = bus.ReadData;
          state_d   = S_SEND;
        end else begin
          rd_cnt_d = rd_cnt_q + RD_W'(1);
          ler_d    = 1'b1;
        end
      end

      S_SEND: begin
        if (!bus.tx_busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end

      // Holds busy for the cycle err is pulsed after a rejected command.
      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset to the idle, all-zero state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_hi_q   <= 8'h00;
      addr_lo_q   <= 8'h00;
      address_q   <= 16'h0000;
      wdata_q     <= 8'h00;
      tx_data_q   <= 8'h00;
      mem_write_q <= 1'b0;
      ler_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_hi_q   <= addr_hi_d;
      addr_lo_q   <= addr_lo_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      mem_write_q <= mem_write_d;
      ler_q       <= ler_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Self-checking bench for uart_mem_ctrl: table of commands with expected
// strobe behaviour, a scoreboard of expected transmitted bytes, and a few
// hand-written sequences for timeout, back-pressure and reset.
module tb_uart_mem_ctrl;
  localparam int TMO = 16;
  localparam int RDW = 2;
  localparam int NV  = 12;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem [0:511];
  logic [15:0] last_addr;
  logic [7:0]  last_wdata;

  uart_mem_ctrl_if bus();

  uart_mem_ctrl #(.MEM_DEPTH(501), .RD_WAIT(RDW), .TIMEOUT(TMO), .ACK_BYTE(8'h4B)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural byte memory answering the controller.
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Address[8:0]] <= bus.WriteData;
  end
  assign bus.ReadData = mem[bus.Address[8:0]];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          e_err;
    bit          e_wr;
    bit          e_rd;
    bit          e_tx;
    logic [7:0]  e_byte;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input vec_t v);
    send_byte(v.op);
    if (v.op == 8'h57 || v.op == 8'h52) begin
      send_byte(v.addr[15:8]);
      send_byte(v.addr[7:0]);
      if (v.op == 8'h57) send_byte(v.data);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && bus.tx_start) begin
      check("tx_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("tx_data", bus.tx_data, exp_q.pop_front());
      check("tx_start_while_busy", bus.tx_busy, 0);
    end
    if (!rst && (bus.MemWrite || bus.ler)) check("wr_rd_excl", bus.MemWrite & bus.ler, 0);
  end

  task automatic run_vec(input int idx, input vec_t v);
    int cnt_err = 0, cnt_wr = 0, cnt_ler = 0, cnt_tx = 0, cnt_busy = 0;
    int f_err = 0, f_wr = 0, f_ler = 0, f_tx = 0;
    int exp_busy;
    bit done = 0;
    logic [31:0] wr_addr = 0, ler_addr = 0;
    logic [7:0]  wr_data = 0;
    if (v.e_tx) exp_q.push_back(v.e_byte);
    send_cmd(v);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.err) begin cnt_err++; if (f_err == 0) f_err = k; end
      if (bus.MemWrite) begin
        cnt_wr++;
        if (f_wr == 0) begin f_wr = k; wr_addr = bus.Address; wr_data = bus.WriteData; end
      end
      if (bus.ler) begin
        cnt_ler++;
        if (f_ler == 0) f_ler = k;
        ler_addr = bus.Address;
      end
      if (bus.tx_start) begin cnt_tx++; if (f_tx == 0) f_tx = k; end
      if (bus.busy) cnt_busy++;
      if (k >= 2 && !bus.busy) begin done = 1; break; end
    end
    if (v.e_wr || v.e_rd) last_addr = v.addr;
    if (v.e_wr) last_wdata = v.data;
    exp_busy = v.e_wr ? 2 : v.e_rd ? RDW + 1 :
               (v.e_err && (v.op == 8'h57 || v.op == 8'h52)) ? 1 : 0;
    $display("vector %0d op=%0h addr=%0h", idx, v.op, v.addr);
    check("vec_done", done, 1);
    check("err_count", cnt_err, v.e_err ? 1 : 0);
    if (v.e_err) check("err_cycle", f_err, 1);
    check("wr_count", cnt_wr, v.e_wr ? 1 : 0);
    if (v.e_wr) begin
      check("wr_cycle", f_wr, 1);
      check("wr_addr", wr_addr, {16'h0000, v.addr});
      check("wr_data", wr_data, v.data);
    end
    check("ler_count", cnt_ler, v.e_rd ? RDW : 0);
    if (v.e_rd) begin
      check("ler_cycle", f_ler, 1);
      check("ler_addr", ler_addr, {16'h0000, v.addr});
    end
    check("tx_count", cnt_tx, v.e_tx ? 1 : 0);
    if (v.e_tx) check("tx_cycle", f_tx, v.e_wr ? 2 : RDW + 1);
    check("busy_cycles", cnt_busy, exp_busy);
    check("addr_hold", bus.Address, {16'h0000, last_addr});
    check("wdata_hold", bus.WriteData, last_wdata);
  endtask

  initial begin
    int   cnt_err, f_err, cnt_ler, cnt_tx, busy_low;
    bit   done;
    vec_t v;

    vecs[0]  = '{8'h57, 16'h0032, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B};
    vecs[1]  = '{8'h52, 16'h0032, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06};
    vecs[2]  = '{8'h41, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{8'h57, 16'h01F5, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{8'h57, 16'h01F4, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B};
    vecs[5]  = '{8'h52, 16'h01F4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[6]  = '{8'h52, 16'h01F5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{8'h57, 16'hFFFF, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{8'h57, 16'h0000, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B};
    vecs[9]  = '{8'h52, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};
    vecs[10] = '{8'h52, 16'h0032, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06};
    vecs[11] = '{8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    last_addr  = 16'h0000;
    last_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_Address", bus.Address, 0);
    check("rst_WriteData", bus.WriteData, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_MemWrite", bus.MemWrite, 0);
    check("rst_ler", bus.ler, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Timeout: stop after the high address byte.
    send_byte(8'h52);
    send_byte(8'h00);
    cnt_err = 0; f_err = 0; cnt_ler = 0; done = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.err) begin cnt_err++; if (f_err == 0) f_err = k; end
      if (bus.ler || bus.MemWrite) cnt_ler++;
      if (k >= 2 && !bus.busy) begin done = 1; break; end
    end
    check("tmo_done", done, 1);
    check("tmo_err_count", cnt_err, 1);
    check("tmo_err_cycle", f_err, TMO);
    check("tmo_no_access", cnt_ler, 0);
    v = '{8'h52, 16'h0032, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06};
    run_vec(100, v);

    // Back-pressure on the read response.
    @(posedge clk); #1;
    bus.tx_busy = 1'b1;
    exp_q.push_back(8'h06);
    send_cmd(v);
    cnt_tx = 0; busy_low = 0; cnt_ler = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.tx_start) cnt_tx++;
      if (!bus.busy) busy_low++;
      if (bus.ler) cnt_ler++;
    end
    check("bp_no_tx", cnt_tx, 0);
    check("bp_busy_held", busy_low, 0);
    check("bp_ler_count", cnt_ler, RDW);
    @(posedge clk); #1;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("bp_tx_start", bus.tx_start, 1);
    @(negedge clk);
    check("bp_busy_fall", bus.busy, 0);

    // Reset while the read strobe is active.
    send_cmd(v);
    @(negedge clk);
    check("rstm_ler_before", bus.ler, 1);
    #1 rst = 1'b1;
    #1;
    check("rstm_ler", bus.ler, 0);
    check("rstm_busy", bus.busy, 0);
    check("rstm_tx_start", bus.tx_start, 0);
    check("rstm_Address", bus.Address, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_addr  = 16'h0000;
    last_wdata = 8'h00;
    cnt_tx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.tx_start || bus.busy) cnt_tx++;
    end
    check("rstm_no_response", cnt_tx, 0);
    v = '{8'h57, 16'h0010, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B};
    run_vec(101, v);
    v = '{8'h52, 16'h0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77};
    run_vec(102, v);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
